// File: rtl/sound_dac_if.sv
// sound_dac_if: level/mute request in, modulated audio bit and frame/ramp status out
interface sound_dac_if;
   logic [7:0] sound;
   logic       mute;
   logic       dac_out;
   logic       frame_stb;
   logic       ramping;
   modport master (output sound, mute, input dac_out, frame_stb, ramping);
   modport slave (input sound, mute, output dac_out, frame_stb, ramping);
endinterface

// File: rtl/sound_dac.sv
// sound_dac: frame-synchronous soft-start/mute level control feeding a PWM or
// first-order sigma-delta 1-bit audio modulator
module sound_dac #(
   parameter logic MODE    = 1'b0,
   parameter logic RAMP_EN = 1'b1
) (
   input logic       clk,
   input logic       rst,
   sound_dac_if.slave bus
);
   typedef enum logic [1:0] {TRACK, RAMP, MUTED} state_t;
   state_t     state, state_nx;
   logic [7:0] cnt, acc, eff, eff_nx;
   logic [8:0] sum;
   logic       bnd;
   assign bnd = cnt == 8'hFF;
   assign sum = {1'b0, acc} + {1'b0, eff};
   assign bus.ramping = state == RAMP;
   // level and state only move on the last cycle of a frame so each frame is glitch-free
   always_comb begin
      state_nx = state;
      eff_nx   = eff;
      if (bnd) begin
         case (state)
            TRACK: begin
               state_nx = bus.mute ? MUTED : TRACK;
               eff_nx   = bus.mute ? 8'h00 : bus.sound;
            end
            RAMP: begin
               state_nx = bus.mute ? MUTED : (eff == bus.sound ? TRACK : RAMP);
               eff_nx   = bus.mute ? 8'h00 :
                          bus.sound > eff ? eff + 8'd1 :
                          bus.sound < eff ? eff - 8'd1 : eff;
            end
            default: begin
               state_nx = bus.mute ? MUTED : RAMP;
               eff_nx   = 8'h00;
            end
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= RAMP_EN ? RAMP : TRACK;
         cnt           <= 8'h00;
         acc           <= 8'h00;
         eff           <= 8'h00;
         bus.dac_out   <= 1'b0;
         bus.frame_stb <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt + 8'd1;
         acc           <= sum[7:0];
         eff           <= eff_nx;
         bus.frame_stb <= bnd;
         bus.dac_out   <= MODE ? sum[8] : (cnt < eff);
      end
   end
endmodule

// File: tb/tb_sound_dac.sv
// tb_sound_dac: directed checks of a PWM soft-start instance and a sigma-delta
// track-from-reset instance sharing clock and reset
module tb_sound_dac;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors = 0;
   sound_dac_if i0 ();
   sound_dac_if i1 ();
   sound_dac #(.MODE(1'b0), .RAMP_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
   sound_dac #(.MODE(1'b1), .RAMP_EN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   // waits for frame_stb, then counts dac_out highs over the following 256 cycles;
   // optionally changes dut0 sound/mute at sample index chg
   task automatic frame(input int chg, input logic [7:0] s, input logic m,
                        output int n0, output int n1, output int same1);
      int b = 0;
      logic p = 1'b0;
      n0 = 0;
      n1 = 0;
      same1 = 0;
      while (!i0.frame_stb && b < 600) begin
         @(negedge clk);
         b++;
      end
      if (!i0.frame_stb) chk("stb_timeout", 0, 1);
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         if (i == chg) begin
            i0.sound = s;
            i0.mute  = m;
         end
         n0 += int'(i0.dac_out);
         n1 += int'(i1.dac_out);
         if (i > 0 && i1.dac_out == p) same1++;
         p = i1.dac_out;
      end
   endtask
   initial begin
      int n0, n1, sm, b;
      i0.sound = 8'h40;
      i0.mute  = 1'b0;
      i1.sound = 8'h80;
      i1.mute  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_dac", int'(i0.dac_out), 0);
      chk("rst_stb", int'(i0.frame_stb), 0);
      chk("rst_ramping0", int'(i0.ramping), 1);
      chk("rst_ramping1", int'(i1.ramping), 0);
      rst = 1'b0;
      for (int k = 1; k <= 64; k++) begin
         frame(-1, 8'h00, 1'b0, n0, n1, sm);
         chk($sformatf("ramp_up_f%0d", k), n0, k);
         if (k == 1) begin
            chk("sdm80_ones", n1, 128);
            chk("sdm80_alt", sm, 0);
            i1.sound = 8'h01;
         end
         if (k == 3) begin
            chk("sdm01_ones", n1, 1);
            i1.sound = 8'h00;
         end
         if (k == 5) chk("sdm00_ones", n1, 0);
         if (k == 63) chk("ramping_f64", int'(i0.ramping), 1);
         if (k == 64) chk("ramping_f65", int'(i0.ramping), 0);
      end
      frame(99, 8'hC0, 1'b0, n0, n1, sm);
      chk("track_chg_cur", n0, 64);
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      chk("track_chg_next", n0, 192);
      i0.sound = 8'h80;
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      chk("track_80", n0, 128);
      frame(9, 8'h80, 1'b1, n0, n1, sm);
      chk("mute_cur", n0, 128);
      chk("muted_ramping", int'(i0.ramping), 0);
      frame(50, 8'h80, 1'b0, n0, n1, sm);
      chk("muted_frame", n0, 0);
      chk("unmute_ramping", int'(i0.ramping), 1);
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      chk("unmute_eff0", n0, 0);
      for (int j = 1; j <= 24; j++) begin
         frame(-1, 8'h00, 1'b0, n0, n1, sm);
         chk($sformatf("reramp_j%0d", j), n0, j <= 16 ? j : 32 - j);
         if (j == 15) i0.sound = 8'h08;
         if (j == 23) chk("ramp_dn_ramping", int'(i0.ramping), 1);
         if (j == 24) chk("ramp_dn_track", int'(i0.ramping), 0);
      end
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      chk("track_08", n0, 8);
      i0.sound = 8'hFF;
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      chk("pwm_ff", n0, 255);
      repeat (77) @(negedge clk);
      chk("pre_rst_dac", int'(i0.dac_out), 1);
      rst = 1'b1;
      #1;
      chk("async_dac", int'(i0.dac_out), 0);
      chk("async_stb", int'(i0.frame_stb), 0);
      chk("async_ramping", int'(i0.ramping), 1);
      @(negedge clk);
      rst = 1'b0;
      b = 0;
      while (!i0.frame_stb && b < 600) begin
         @(negedge clk);
         b++;
      end
      chk("first_stb_delay", b, 256);
      frame(-1, 8'h00, 1'b0, n0, n1, sm);
      chk("post_rst_f1", n0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
